// File: rtl/tri_solve_pkg.sv
// ---------------------------------------------------------------------------
// tri_solve_pkg
// Shared types and helpers for the N x N triangular solver.
//   state_t : solver FSM states
//   MAXW    : working width of the saturation helper (wide enough for any
//             accumulator the solver can be configured with)
//   clog2   : ceiling log2 helper for parameter derivation
//   acc_w   : accumulator / dividend width for a given element width and order
//   idx     : row-major flat index of element (r, c) of an n x n matrix
//   sat     : clamp a signed value into the signed range of dw bits
// ---------------------------------------------------------------------------
package tri_solve_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROW_INIT,
        MAC,
        DIV,
        STORE,
        DONE
    } state_t;

    localparam int MAXW = 128;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Product is 2*dw bits; up to n-1 products and b[i] are summed.
    function automatic int acc_w(input int dw, input int n);
        return 2 * dw + clog2(n);
    endfunction

    function automatic int idx(input int r, input int c, input int n);
        return r * n + c;
    endfunction

    function automatic logic signed [MAXW-1:0] sat(input logic signed [MAXW-1:0] v,
                                                   input int dw);
        logic signed [MAXW-1:0] hi;
        logic signed [MAXW-1:0] lo;
        hi = $signed((MAXW'(1) << (dw - 1)) - MAXW'(1));
        lo = ~hi;   // -hi - 1 == -2^(dw-1)
        if (v > hi)      sat = hi;
        else if (v < lo) sat = lo;
        else             sat = v;
    endfunction

endpackage

// File: rtl/tri_solve_nxn_if.sv
// ---------------------------------------------------------------------------
// tri_solve_nxn_if
// Request/result bundle of the triangular solver.
//   master (requester): drives start, lower, [unit_diag], A_in, b_in;
//                       observes busy, done, x_out, singular, overflow
//   slave  (solver)   : the mirror image
// unit_diag exists only when TRI_SOLVE_UNIT_DIAG_EN is defined.
// ---------------------------------------------------------------------------
interface tri_solve_nxn_if #(
    parameter int N  = 4,
    parameter int DW = 32
);
    logic                start;
    logic                lower;
`ifdef TRI_SOLVE_UNIT_DIAG_EN
    logic                unit_diag;
`endif
    logic [N*N*DW-1:0]   A_in;
    logic [N*DW-1:0]     b_in;
    logic                busy;
    logic                done;
    logic [N*DW-1:0]     x_out;
    logic                singular;
    logic                overflow;

    modport master (
        output start, lower,
`ifdef TRI_SOLVE_UNIT_DIAG_EN
        output unit_diag,
`endif
        output A_in, b_in,
        input  busy, done, x_out, singular, overflow
    );

    modport slave (
        input  start, lower,
`ifdef TRI_SOLVE_UNIT_DIAG_EN
        input  unit_diag,
`endif
        input  A_in, b_in,
        output busy, done, x_out, singular, overflow
    );
endinterface

// File: rtl/tri_solve_div.sv
// ---------------------------------------------------------------------------
// tri_solve_div
// AW-bit / DW-bit signed restoring divider, quotient truncated toward zero.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : load operands; the first quotient bit is resolved this edge
//   dividend  : AW-bit signed
//   divisor   : DW-bit signed
//   quotient  : AW-bit signed, held until the next start
//   valid     : high from AW cycles after start (inclusive of the start
//               cycle's edge count) until the next start
//   dz        : divisor was zero; quotient reads 0
// Magnitudes are divided and the sign applied at the output. The remainder
// never exceeds |divisor| <= 2^(DW-1), so a DW-bit remainder register is enough.
// ---------------------------------------------------------------------------
module tri_solve_div
    import tri_solve_pkg::*;
#(
    parameter int AW = 66,
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic signed [AW-1:0] dividend,
    input  logic signed [DW-1:0] divisor,
    output logic signed [AW-1:0] quotient,
    output logic                 valid,
    output logic                 dz
);
    localparam int CW = clog2(AW + 1);

    logic [DW-1:0] rem_reg;
    logic [AW-1:0] quo_reg;
    logic [DW-1:0] dvs_reg;
    logic [CW-1:0] cnt_reg;
    logic          neg_reg;
    logic          dz_reg;
    logic          valid_reg;

    logic [AW-1:0] mag_a;
    logic [DW-1:0] mag_d;
    logic [DW-1:0] src_rem;
    logic [AW-1:0] src_quo;
    logic [DW-1:0] src_dvs;
    logic [DW:0]   shifted;
    logic [DW:0]   diff;
    logic          fits;
    logic [DW-1:0] step_rem;
    logic [AW-1:0] step_quo;

    assign mag_a = dividend[AW-1] ? $unsigned(-dividend) : $unsigned(dividend);
    assign mag_d = divisor[DW-1]  ? $unsigned(-divisor)  : $unsigned(divisor);

    // On start the iteration works directly on the incoming operands so the
    // whole division takes exactly AW edges.
    assign src_rem = start ? '0    : rem_reg;
    assign src_quo = start ? mag_a : quo_reg;
    assign src_dvs = start ? mag_d : dvs_reg;

    assign shifted  = {src_rem, src_quo[AW-1]};
    assign diff     = shifted - {1'b0, src_dvs};
    assign fits     = ~diff[DW];                 // no borrow: shifted >= divisor
    assign step_rem = fits ? diff[DW-1:0] : shifted[DW-1:0];
    assign step_quo = {src_quo[AW-2:0], fits};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_reg   <= '0;
            quo_reg   <= '0;
            dvs_reg   <= '0;
            cnt_reg   <= '0;
            neg_reg   <= 1'b0;
            dz_reg    <= 1'b0;
            valid_reg <= 1'b0;
        end else if (start) begin
            rem_reg   <= step_rem;
            quo_reg   <= step_quo;
            dvs_reg   <= mag_d;
            cnt_reg   <= CW'(AW - 1);
            neg_reg   <= dividend[AW-1] ^ divisor[DW-1];
            dz_reg    <= (divisor == '0);
            valid_reg <= 1'b0;
        end else if (cnt_reg != '0) begin
            rem_reg <= step_rem;
            quo_reg <= step_quo;
            cnt_reg <= cnt_reg - 1'b1;
            if (cnt_reg == CW'(1)) valid_reg <= 1'b1;
        end
    end

    assign quotient = dz_reg  ? '0 :
                      neg_reg ? -$signed(quo_reg) : $signed(quo_reg);
    assign valid    = valid_reg;
    assign dz       = dz_reg;

endmodule

// File: rtl/tri_solve_nxn.sv
// ---------------------------------------------------------------------------
// tri_solve_nxn
// N x N signed-integer triangular solver: backward substitution on U
// (lower=0, rows N-1..0) or forward substitution on L (lower=1, rows 0..N-1),
// using one multiply-accumulate per cycle and one sequential divider.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : tri_solve_nxn_if.slave
//         start/lower(/unit_diag) request, A_in (row-major), b_in operands,
//         busy, done pulse, x_out, singular, overflow results
// Optional feature macro: TRI_SOLVE_UNIT_DIAG_EN adds unit_diag; when set for
// a solve, the diagonal is taken as 1 and the divide step is skipped.
// ---------------------------------------------------------------------------
module tri_solve_nxn
    import tri_solve_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    tri_solve_nxn_if.slave bus
);
    localparam int AW = acc_w(DW, N);
    localparam int IW = (clog2(N) < 1) ? 1 : clog2(N);
    localparam int CW = clog2(AW + N + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t                state_reg;
    logic                  lower_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  singular_reg;
    logic                  overflow_reg;
    logic [N*DW-1:0]       x_out_reg;
    logic signed [DW-1:0]  a_reg [N][N];
    logic signed [DW-1:0]  b_reg [N];
    logic signed [DW-1:0]  x_reg [N];
    logic [IW-1:0]         i_reg;
    logic [IW-1:0]         j_reg;
    logic [CW-1:0]         cnt_reg;
    logic signed [AW-1:0]  acc_reg;

    logic                  unit_eff;
`ifdef TRI_SOLVE_UNIT_DIAG_EN
    logic                  unit_reg;
    assign unit_eff = unit_reg;
`else
    assign unit_eff = 1'b0;
`endif

    // Unpack the flat operand buses.
    logic signed [DW-1:0] a_in_w [N][N];
    logic signed [DW-1:0] b_in_w [N];

    generate
        for (genvar gi = 0; gi < N * N; gi++) begin : g_a_unpack
            assign a_in_w[gi / N][gi % N] = bus.A_in[idx(gi / N, gi % N, N) * DW +: DW];
        end
        for (genvar gi = 0; gi < N; gi++) begin : g_b_unpack
            assign b_in_w[gi] = bus.b_in[gi * DW +: DW];
        end
    endgenerate

    // Datapath for the current row i and solved column j.
    logic signed [DW-1:0]   a_ij;
    logic signed [DW-1:0]   a_ii;
    logic signed [DW-1:0]   x_j;
    logic signed [DW-1:0]   b_i;
    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   acc_mac;
    logic signed [AW-1:0]   b_ext;
    logic [CW-1:0]          k_row;
    logic                   last_row;

    assign a_ij    = a_reg[i_reg][j_reg];
    assign a_ii    = a_reg[i_reg][i_reg];
    assign x_j     = x_reg[j_reg];
    assign b_i     = b_reg[i_reg];
    assign prod    = a_ij * x_j;
    assign acc_mac = acc_reg - {{(AW - 2 * DW){prod[2*DW-1]}}, prod};
    assign b_ext   = {{(AW - DW){b_i[DW-1]}}, b_i};
    // Rows already solved before row i: they are exactly the MAC terms.
    assign k_row    = lower_reg ? CW'(i_reg) : CW'(LAST_IDX - i_reg);
    assign last_row = lower_reg ? (i_reg == LAST_IDX) : (i_reg == '0);

    // The divider is launched on the edge that enters DIV, with the final
    // accumulator value computed combinationally, so DIV lasts AW cycles.
    logic                  div_start;
    logic signed [AW-1:0]  div_dividend;
    logic signed [AW-1:0]  div_q;
    logic                  div_valid;
    logic                  div_dz;

    assign div_start = ~unit_eff &
                       (((state_reg == ROW_INIT) && (k_row == '0)) ||
                        ((state_reg == MAC) && (cnt_reg == CW'(1))));
    assign div_dividend = (state_reg == ROW_INIT) ? b_ext : acc_mac;

    tri_solve_div #(
        .AW (AW),
        .DW (DW)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (a_ii),
        .quotient (div_q),
        .valid    (div_valid),
        .dz       (div_dz)
    );

    // Result of the row, clamped to DW bits.
    logic signed [AW-1:0]   q_sel;
    logic signed [MAXW-1:0] q_ext;
    logic signed [MAXW-1:0] sat_full;
    logic                   sat_hit;
    logic                   row_sing;

    assign q_sel    = unit_eff ? acc_reg : div_q;
    assign q_ext    = {{(MAXW - AW){q_sel[AW-1]}}, q_sel};
    assign sat_full = sat(q_ext, DW);
    assign sat_hit  = (sat_full != q_ext);
    assign row_sing = ~unit_eff & div_dz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            lower_reg    <= 1'b0;
`ifdef TRI_SOLVE_UNIT_DIAG_EN
            unit_reg     <= 1'b0;
`endif
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            singular_reg <= 1'b0;
            overflow_reg <= 1'b0;
            x_out_reg    <= '0;
            i_reg        <= '0;
            j_reg        <= '0;
            cnt_reg      <= '0;
            acc_reg      <= '0;
            for (int r = 0; r < N; r++) begin
                b_reg[r] <= '0;
                x_reg[r] <= '0;
                for (int c = 0; c < N; c++) a_reg[r][c] <= '0;
            end
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // A start coinciding with the done pulse is not accepted.
                    if (bus.start && !done_reg) begin
                        lower_reg <= bus.lower;
`ifdef TRI_SOLVE_UNIT_DIAG_EN
                        unit_reg  <= bus.unit_diag;
`endif
                        busy_reg  <= 1'b1;
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    for (int r = 0; r < N; r++) begin
                        b_reg[r] <= b_in_w[r];
                        x_reg[r] <= '0;
                        for (int c = 0; c < N; c++) a_reg[r][c] <= a_in_w[r][c];
                    end
                    singular_reg <= 1'b0;
                    overflow_reg <= 1'b0;
                    i_reg        <= lower_reg ? '0 : LAST_IDX;
                    state_reg    <= ROW_INIT;
                end
                ROW_INIT: begin
                    acc_reg <= b_ext;
                    j_reg   <= lower_reg ? '0 : LAST_IDX;
                    cnt_reg <= k_row;
                    if (k_row == '0) state_reg <= unit_eff ? STORE : DIV;
                    else             state_reg <= MAC;
                end
                MAC: begin
                    acc_reg <= acc_mac;
                    j_reg   <= lower_reg ? j_reg + 1'b1 : j_reg - 1'b1;
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == CW'(1)) state_reg <= unit_eff ? STORE : DIV;
                end
                DIV: begin
                    if (div_valid) state_reg <= STORE;
                end
                STORE: begin
                    x_reg[i_reg] <= row_sing ? '0 : sat_full[DW-1:0];
                    if (row_sing)            singular_reg <= 1'b1;
                    if (sat_hit && !row_sing) overflow_reg <= 1'b1;
                    if (last_row) begin
                        state_reg <= DONE;
                    end else begin
                        i_reg     <= lower_reg ? i_reg + 1'b1 : i_reg - 1'b1;
                        state_reg <= ROW_INIT;
                    end
                end
                DONE: begin
                    for (int r = 0; r < N; r++) x_out_reg[r*DW +: DW] <= x_reg[r];
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.x_out    = x_out_reg;
    assign bus.singular = singular_reg;
    assign bus.overflow = overflow_reg;

endmodule
